arbiter21_rr: RTL and testbench

- Round-robin 2-to-1 merge arbiter for the NoC tree. It is the upward counterpart of the 1-to-2 address decoder node.
- It takes packets from two child channels (In0, In1) and forwards them one at a time onto a single parent channel (Out). A winner-ID side channel (S) travels with each packet.
- A 2-entry output buffer decouples arbitration from downstream backpressure.
- Per-input grant counters are provided for fairness checks and profiling.

---
 rtl/arbiter21_rr_if.sv | 35 +++
 rtl/arbiter21_rr.sv | 103 ++++++++++
 tb/tb_arbiter21_rr.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/arbiter21_rr_if.sv
// ---- arbiter21_rr_if: child/parent handshake bundle for the 2:1 merge arbiter (rev 1.0)
`default_nettype none

interface arbiter21_rr_if #(
  parameter int W = 9
);
  logic [W-1:0] in0_data;
  logic         in0_valid;
  logic         in0_ready;
  logic [W-1:0] in1_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [W-1:0] out_data;
  logic         out_sel;
  logic         out_valid;
  logic         out_ready;

  // Environment side: producers on In0/In1, consumer on Out.
  modport master (
    output in0_data, in0_valid, input in0_ready,
    output in1_data, in1_valid, input in1_ready,
    input  out_data, out_sel, out_valid,
    output out_ready
  );

  // Arbiter side.
  modport slave (
    input  in0_data, in0_valid, output in0_ready,
    input  in1_data, in1_valid, output in1_ready,
    output out_data, out_sel, out_valid,
    input  out_ready
  );
endinterface

`default_nettype wire

// File: rtl/arbiter21_rr.sv
// ---- arbiter21_rr: round-robin 2:1 merge arbiter with 2-entry output FIFO and grant counters (rev 1.0)
`default_nettype none

module arbiter21_rr #(
  parameter int W     = 9,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             _RESET,
  arbiter21_rr_if.slave    bus,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  logic [1:0]       count_q, count_d;
  logic [W-1:0]     data0_q, data0_d;
  logic [W-1:0]     data1_q, data1_d;
  logic             sel0_q, sel0_d;
  logic             sel1_q, sel1_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             pop;
  logic             space;
  logic             gnt0;
  logic             gnt1;
  logic             push;
  logic [W-1:0]     push_data;
  logic [1:0]       fill;

  // Arbitration; readies are forced low while reset is asserted.
  always_comb begin
    pop       = (count_q != 2'd0) && bus.out_ready;
    space     = (count_q != 2'd2) || pop;
    gnt0      = _RESET && space && bus.in0_valid && (!bus.in1_valid || last_q);
    gnt1      = _RESET && space && bus.in1_valid && (!bus.in0_valid || !last_q);
    push      = gnt0 || gnt1;
    push_data = gnt1 ? bus.in1_data : bus.in0_data;
    fill      = count_q - {1'b0, pop};
  end

  // Slot 0 is always the head; a pop shifts slot 1 down before the push lands.
  always_comb begin
    count_d = fill + {1'b0, push};
    data0_d = data0_q;
    sel0_d  = sel0_q;
    data1_d = data1_q;
    sel1_d  = sel1_q;
    last_d  = last_q;
    cnt0_d  = cnt0_q + {{(CNT_W-1){1'b0}}, gnt0};
    cnt1_d  = cnt1_q + {{(CNT_W-1){1'b0}}, gnt1};

    if (pop) begin
      data0_d = data1_q;
      sel0_d  = sel1_q;
    end

    if (push) begin
      last_d = gnt1;
      if (fill == 2'd0) begin
        data0_d = push_data;
        sel0_d  = gnt1;
      end else begin
        data1_d = push_data;
        sel1_d  = gnt1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      count_q <= 2'd0;
      data0_q <= '0;
      data1_q <= '0;
      sel0_q  <= 1'b0;
      sel1_q  <= 1'b0;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      count_q <= count_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      sel0_q  <= sel0_d;
      sel1_q  <= sel1_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign bus.in0_ready = gnt0;
  assign bus.in1_ready = gnt1;
  assign bus.out_data  = data0_q;
  assign bus.out_sel   = sel0_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign grant_cnt0    = cnt0_q;
  assign grant_cnt1    = cnt1_q;

endmodule

`default_nettype wire

// File: tb/tb_arbiter21_rr.sv
// ---- tb_arbiter21_rr: vector table plus output scoreboard for arbiter21_rr (rev 1.0)
`default_nettype none

module tb_arbiter21_rr;
  localparam int W = 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst2_n;
  logic [7:0] gc0, gc1;
  logic [1:0] gw0, gw1;

  always #5 clk = ~clk;

  arbiter21_rr_if #(.W(W)) bus ();
  arbiter21_rr_if #(.W(W)) bus2 ();

  arbiter21_rr #(.W(W), .CNT_W(8)) dut (
    .CLK       (clk),
    ._RESET    (rst_n),
    .bus       (bus),
    .grant_cnt0(gc0),
    .grant_cnt1(gc1)
  );

  arbiter21_rr #(.W(W), .CNT_W(2)) dut2 (
    .CLK       (clk),
    ._RESET    (rst2_n),
    .bus       (bus2),
    .grant_cnt0(gw0),
    .grant_cnt1(gw1)
  );

  typedef struct {
    logic         rst_n;
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    logic         ordy;
    logic         er0;
    logic         er1;
    logic         eov;
    logic [7:0]   ec0;
    logic [7:0]   ec1;
  } vec_t;

  vec_t         vecs[$];
  logic [W:0]   sb[$];
  int           errors = 0;
  int           checks = 0;

  task automatic add(input logic rn, input logic v0, input logic [W-1:0] d0,
                     input logic v1, input logic [W-1:0] d1, input logic ordy,
                     input logic er0, input logic er1, input logic eov,
                     input logic [7:0] ec0, input logic [7:0] ec1);
    vec_t t;
    t.rst_n = rn; t.v0 = v0; t.d0 = d0; t.v1 = v1; t.d1 = d1; t.ordy = ordy;
    t.er0 = er0; t.er1 = er1; t.eov = eov; t.ec0 = ec0; t.ec1 = ec1;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    //   rn v0 d0      v1 d1      ordy r0 r1 ov cnt0 cnt1
    add(1, 1, 9'h1A5, 0, 9'h000, 1,   1, 0, 0, 0, 0);  // single in0 packet
    add(1, 0, 9'h000, 0, 9'h000, 1,   0, 0, 1, 1, 0);
    add(1, 0, 9'h000, 1, 9'h0F0, 1,   0, 1, 0, 1, 0);  // leaves last_grant=1
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   1, 0, 1, 1, 1);  // alternation 0,1,...
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   0, 1, 1, 2, 1);
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   1, 0, 1, 2, 2);
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   0, 1, 1, 3, 2);
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   1, 0, 1, 3, 3);
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   0, 1, 1, 4, 3);
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   1, 0, 1, 4, 4);
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   0, 1, 1, 5, 4);
    add(1, 0, 9'h000, 0, 9'h000, 1,   0, 0, 1, 5, 5);  // drain
    add(1, 1, 9'h055, 1, 9'h1AA, 0,   1, 0, 0, 5, 5);  // backpressure fill
    add(1, 1, 9'h055, 1, 9'h1AA, 0,   0, 1, 1, 6, 5);
    add(1, 1, 9'h055, 1, 9'h1AA, 0,   0, 0, 1, 6, 6);  // full, stalled
    add(1, 1, 9'h055, 1, 9'h1AA, 0,   0, 0, 1, 6, 6);
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   1, 0, 1, 6, 6);  // push+pop at full
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   0, 1, 1, 7, 6);
    add(1, 0, 9'h000, 1, 9'h123, 1,   0, 1, 1, 7, 7);  // full, in1 only
    add(1, 0, 9'h000, 0, 9'h000, 1,   0, 0, 1, 7, 8);
    add(1, 0, 9'h000, 0, 9'h000, 1,   0, 0, 1, 7, 8);
    add(1, 0, 9'h000, 0, 9'h000, 1,   0, 0, 0, 7, 8);  // empty, idle
    add(1, 0, 9'h000, 0, 9'h000, 0,   0, 0, 0, 7, 8);
    add(1, 1, 9'h011, 0, 9'h000, 0,   1, 0, 0, 7, 8);  // fill before reset
    add(1, 0, 9'h000, 1, 9'h022, 0,   0, 1, 1, 8, 8);
    add(0, 1, 9'h055, 1, 9'h1AA, 0,   0, 0, 1, 8, 9);  // mid-run reset
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   1, 0, 0, 0, 0);  // In0 wins after reset
    add(1, 1, 9'h055, 1, 9'h1AA, 1,   0, 1, 1, 1, 0);
    add(1, 0, 9'h000, 0, 9'h000, 1,   0, 0, 1, 1, 1);
    add(1, 0, 9'h000, 0, 9'h000, 1,   0, 0, 0, 1, 1);

    rst2_n = 1'b0;
    bus2.in0_valid = 1'b0; bus2.in0_data = '0;
    bus2.in1_valid = 1'b0; bus2.in1_data = '0;
    bus2.out_ready = 1'b0;

    // Reset with both inputs offering: nothing may be accepted.
    rst_n = 1'b0;
    bus.in0_valid = 1'b1; bus.in0_data = 9'h0AB;
    bus.in1_valid = 1'b1; bus.in1_data = 9'h0CD;
    bus.out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("reset in0_ready", bus.in0_ready, 0);
    chk("reset in1_ready", bus.in1_ready, 0);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset out_sel", bus.out_sel, 0);
    chk("reset grant_cnt0", gc0, 0);
    chk("reset grant_cnt1", gc1, 0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst_n = v.rst_n;
      bus.in0_valid = v.v0; bus.in0_data = v.d0;
      bus.in1_valid = v.v1; bus.in1_data = v.d1;
      bus.out_ready = v.ordy;
      @(negedge clk);
      chk($sformatf("v%0d in0_ready", i), bus.in0_ready, v.er0);
      chk($sformatf("v%0d in1_ready", i), bus.in1_ready, v.er1);
      chk($sformatf("v%0d out_valid", i), bus.out_valid, v.eov);
      chk($sformatf("v%0d grant_cnt0", i), gc0, v.ec0);
      chk($sformatf("v%0d grant_cnt1", i), gc1, v.ec1);
      if (v.eov) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL v%0d head: got %0h expected an empty scoreboard entry", i, {bus.out_sel, bus.out_data});
        end else begin
          chk($sformatf("v%0d head {sel,data}", i), {bus.out_sel, bus.out_data}, sb[0]);
          if (v.ordy) void'(sb.pop_front());
        end
      end
      if (v.er0) sb.push_back({1'b0, v.d0});
      if (v.er1) sb.push_back({1'b1, v.d1});
      if (!v.rst_n) sb.delete();
      @(posedge clk); #1;
    end
    chk("scoreboard drained", sb.size(), 0);

    // Counter wrap on the CNT_W=2 instance: 5 accepts leave grant_cnt0 at 1.
    rst2_n = 1'b1;
    bus2.in0_valid = 1'b1; bus2.in0_data = 9'h001;
    bus2.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("wrap%0d in0_ready", k), bus2.in0_ready, 1);
      chk($sformatf("wrap%0d grant_cnt0", k), gw0, k % 4);
      @(posedge clk); #1;
    end
    bus2.in0_valid = 1'b0;
    @(negedge clk);
    chk("wrap final grant_cnt0", gw0, 1);
    chk("wrap final grant_cnt1", gw1, 0);
    chk("wrap final out_valid", bus2.out_valid, 1);
    chk("wrap final out_data", bus2.out_data, 9'h001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
